mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter and sequencer that shares the 4:1 registered mux datapath (inputs A/B/C/D, select `sel_i`, enable `enb`, output `out`) between four requesters. It picks one requester per transaction, drives `sel_i`/`enb` to the mux, and waits the mux latency. It then returns the captured mux output to the winner with a tagged response pulse. It sits between the requester agents and the mux instance, in the same clock domain.

## Interface
- `WIDTH`, 8: data width of mux output and response data.
- `MUX_LAT`, 1: cycles from `enb` high at a clock edge until `out` is valid for sampling (1..4).
- `MAX_BURST`, 4: maximum back-to-back transfers per grant; used only with the burst feature.

- `clk`  in  1  system clock, all logic on rising edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `req`  in  4  per-requester request, level; bit i = requester i (mux input A..D).
- `gnt`  out  4  one-hot grant; held for the whole transaction.
- `sel_i`  out  2  mux select to datapath, index of the winner.
- `enb`  out  1  mux enable, one-cycle pulse per transfer.
- `mux_out`  in  WIDTH  mux `out` returned from datapath.
- `rsp_valid`  out  1  one-cycle pulse: `rsp_data` is valid.
- `rsp_id`  out  2  index of the requester owning the response.
- `rsp_data`  out  WIDTH  captured `mux_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RSP.
- Round-robin pointer `ptr` (2 bits) = highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 mod 4.
- IDLE: if any `req` bit is set, the winner w is the first set bit in search order. Next edge: `gnt`=1<<w, `sel_i`=w, `enb`=1, go to ISSUE. If no bit is set, stay in IDLE with all outputs idle.
- ISSUE: lasts one cycle, with `enb` high for exactly this cycle. Go to WAIT and load the wait counter with MUX_LAT-1.
- WAIT: count down. When the counter reads 0, capture `mux_out` into `rsp_data` and `rsp_id`=w, and go to RSP.
- RSP: `rsp_valid`=1 for this cycle only, and `ptr`←w+1 mod 4. Re-arbitration happens in this same cycle:
  - The served requester's `req` is masked (without burst).
  - If any other bit is set, the next edge goes to ISSUE with the new winner. `gnt` switches directly from old one-hot to new one-hot with no zero cycle.
  - Otherwise go to IDLE and set `gnt`=0.
- `sel_i` holds its last value while idle; the mux ignores it when `enb`=0.
- `req` is sampled only in IDLE and RSP. Changes in other states are ignored. Dropping `req` mid-transaction does not abort it.
- The requester drops `req` no earlier than the cycle after it sees `rsp_valid`.
- Fairness: with all four requesting continuously, grants rotate 0,1,2,3,0,… No requester waits more than 3 transactions.

## Timing
- Reset (edge with `rstn`=0) forces: state IDLE, `gnt`=0, `sel_i`=0, `enb`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, `ptr`=0, burst count 0.
- Reset mid-transaction aborts it. No `rsp_valid` is produced, and a pending mux result is discarded.
- Latency from `req` high in IDLE at edge T:
  - `gnt`/`enb` high after T+1.
  - Capture at T+1+MUX_LAT.
  - `rsp_valid` high after T+2+MUX_LAT (MUX_LAT=1: req→rsp 3 cycles).
- Back-to-back throughput: one transfer per MUX_LAT+2 cycles (ISSUE, WAIT×MUX_LAT, RSP).
- Simultaneous requests: resolved only by `ptr`; ties cannot occur.
- Inputs at the same edge as reset are ignored.

## Configuration
- `MUX_ARB_BURST_EN` defined:
  - In RSP the served requester's `req` is not masked.
  - If it is still high and its burst count < MAX_BURST, it keeps the grant: next state ISSUE, same w, burst count +1, `ptr` unchanged.
  - When the burst count reaches MAX_BURST or `req` drops, normal rotation resumes: `ptr`←w+1 and burst count←0.
  - Burst count increments once per completed transfer.
- Undefined: one transfer per grant; the burst counter and MAX_BURST are not synthesized.

## Test plan
- Reset then `req`=4'b0100 held until `rsp_valid`, with mux C=8'h5A (MUX_LAT=1) → `gnt`=4'b0100 and `sel_i`=2 and `enb` one cycle after edge 1; `rsp_valid` after edge 3 with `rsp_id`=2, `rsp_data`=8'h5A; IDLE afterwards.
- `req`=4'b1111 held continuously with A..D=11,22,33,44 → `rsp_id` sequence 0,1,2,3,0 and data 11,22,33,44,11; `rsp_valid` every 3 cycles; `gnt` never 0 between transfers.
- `ptr`=2 (after serving 1) and `req`=4'b0011 → winner 0 before 1; then `req`=4'b1001 → winner 3 before 0.
- `rstn`=0 for one edge while in WAIT with MUX_LAT=3 → no `rsp_valid`; all outputs zero on the next cycle; the next request from requester 3 is granted after requester 0..2 are checked (`ptr`=0).
- Burst (`MUX_ARB_BURST_EN`, MAX_BURST=4): `req`=4'b0011 held → `rsp_id` 0,0,0,0,1,1,1,1,0; without the macro → 0,1,0,1.
- `req` pulsed for only one cycle in IDLE → full transaction completes with exactly one `rsp_valid`; `req` toggling during WAIT has no effect.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter/sequencer sharing a 4:1 registered mux among four requesters.
// Define MUX_ARB_BURST_EN to let a winner keep its grant for up to MAX_BURST back-to-back transfers.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MUX_LAT   = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel_i,
  output logic             enb,
  input  logic [WIDTH-1:0] mux_out,
  output logic             rsp_valid,
  output logic [1:0]       rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;
  if (MUX_LAT < 1 || MUX_LAT > 4 || MAX_BURST < 1) begin : g_bad_param
    $error("mux_rr_arbiter: MUX_LAT must be 1..4 and MAX_BURST >= 1");
  end
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, cnt_q, cnt_d, rsp_id_q, rsp_id_d;
  logic [1:0]       base, win, idx;
  logic [3:0]       gnt_q, gnt_d, cand;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             found, keep;
`ifdef MUX_ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
`endif
  assign gnt       = gnt_q;
  assign sel_i     = sel_q;
  assign enb       = state_q == ISSUE;
  assign rsp_valid = state_q == RSP;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = state_q != IDLE;
  always_comb begin
`ifdef MUX_ARB_BURST_EN
    keep   = state_q == RSP && req[sel_q] && bcnt_q < BW'(MAX_BURST - 1);
    cand   = req;
    bcnt_d = bcnt_q;
`else
    keep = 1'b0;
    cand = req & ~(state_q == RSP ? gnt_q : 4'b0);
`endif
    // after a transfer the search restarts just past the served requester
    base  = state_q == RSP ? sel_q + 2'd1 : ptr_q;
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        gnt_d   = 4'b1 << win;
        sel_d   = win;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 2'(MUX_LAT - 1);
      end
      WAIT: if (cnt_q == 2'd0) begin
        state_d    = RSP;
        rsp_data_d = mux_out;
        rsp_id_d   = sel_q;
      end else cnt_d = cnt_q - 2'd1;
      default: if (keep) begin
        state_d = ISSUE;
`ifdef MUX_ARB_BURST_EN
        bcnt_d = bcnt_q + BW'(1);
`endif
      end else begin
        ptr_d   = sel_q + 2'd1;
`ifdef MUX_ARB_BURST_EN
        bcnt_d = '0;
`endif
        state_d = found ? ISSUE : IDLE;
        gnt_d   = found ? 4'b1 << win : 4'b0;
        sel_d   = found ? win : sel_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
`ifdef MUX_ARB_BURST_EN
      bcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
`ifdef MUX_ARB_BURST_EN
      bcnt_q     <= bcnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for mux_rr_arbiter driving a behavioural registered 4:1 mux (MUX_LAT=1).
module tb_mux_rr_arbiter;
  logic       clk = 0;
  logic       rstn = 0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] sel_i;
  logic       enb;
  logic [7:0] mux_out = '0;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] din [4];
  logic [9:0] sb [$];
  int compared = 0;
  int mismatched = 0;
  int rsp_seen = 0;

  mux_rr_arbiter #(.WIDTH(8), .MUX_LAT(1), .MAX_BURST(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .sel_i(sel_i), .enb(enb),
    .mux_out(mux_out), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (enb) mux_out <= din[sel_i];

  always @(negedge clk) if (rsp_valid) begin
    rsp_seen++;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
    end else begin
      logic [9:0] e;
      e = sb.pop_front();
      if ({rsp_id, rsp_data} !== e) begin
        mismatched++;
        $display("FAIL rsp: got id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e[9:8], e[7:0]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id);
    sb.push_back({id, din[id]});
  endtask

  task automatic set_data(input logic [7:0] a, b, c, d);
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
  endtask

  task automatic do_reset();
    rstn = 0;
    req = '0;
    tick();
    tick();
    rstn = 1;
  endtask

  task automatic wait_rsp(input int n, input string name);
    int t = rsp_seen + n;
    int b = 0;
    while (rsp_seen < t && b < 60) begin
      tick();
      b++;
    end
    compared++;
    if (rsp_seen < t) begin
      mismatched++;
      $display("FAIL %s_timeout: got %0d responses, required %0d", name, rsp_seen, t);
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({gnt, sel_i, enb, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got gnt=%b sel=%0d enb=%b rv=%b id=%0d data=%h busy=%b, required all zero",
               gnt, sel_i, enb, rsp_valid, rsp_id, rsp_data, busy);
    end
  endtask

  task automatic test_single();
    set_data(8'h01, 8'h02, 8'h5A, 8'h04);
    req = 4'b0100;
    push(2);
    tick();
    compared++;
    if ({gnt, sel_i, enb} !== {4'b0100, 2'd2, 1'b1}) begin
      mismatched++;
      $display("FAIL single_issue: got gnt=%b sel=%0d enb=%b, required gnt=0100 sel=2 enb=1", gnt, sel_i, enb);
    end
    tick();
    compared++;
    if ({enb, busy} !== 2'b01) begin
      mismatched++;
      $display("FAIL single_wait: got enb=%b busy=%b, required enb=0 busy=1", enb, busy);
    end
    tick();
    compared++;
    if (rsp_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL single_rsp_time: got rsp_valid=%b, required 1", rsp_valid);
    end
    tick();
    req = '0;
    compared++;
    if ({gnt, busy, rsp_valid} !== 6'b0) begin
      mismatched++;
      $display("FAIL single_idle: got gnt=%b busy=%b rv=%b, required all zero", gnt, busy, rsp_valid);
    end
    tick();
  endtask

  task automatic test_all_four();
    do_reset();
    set_data(8'h11, 8'h22, 8'h33, 8'h44);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push(2'(i));
    for (int c = 1; c <= 15; c++) begin
      tick();
      compared++;
      if (gnt === 4'b0000) begin
        mismatched++;
        $display("FAIL rr_gnt_gap: got gnt=0000 at cycle %0d, required non-zero", c);
      end
      if (rsp_valid) begin
        compared++;
        if (c % 3 != 0) begin
          mismatched++;
          $display("FAIL rr_rsp_period: got rsp_valid at cycle %0d, required multiple of 3", c);
        end
      end
    end
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rr_end_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_ptr_order();
    do_reset();
    set_data(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    req = 4'b0010;
    push(1);
    wait_rsp(1, "ptr_prime");
    tick();
    req = 4'b0011;
    push(0);
    push(1);
    wait_rsp(2, "ptr_0011");
    req = 4'b0010;
    tick();
    req = 4'b1001;
    push(3);
    push(0);
    wait_rsp(2, "ptr_1001");
    req = 4'b0001;
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_reset_abort();
    req = 4'b0100;
    tick();
    tick();
    compared++;
    if (busy !== 1'b1 || enb !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_setup: got busy=%b enb=%b, required busy=1 enb=0", busy, enb);
    end
    rstn = 0;
    req = '0;
    tick();
    compared++;
    if ({gnt, sel_i, enb, rsp_valid, rsp_id, rsp_data, busy} !== '0) begin
      mismatched++;
      $display("FAIL abort_outputs: got gnt=%b sel=%0d enb=%b rv=%b id=%0d data=%h busy=%b, required all zero",
               gnt, sel_i, enb, rsp_valid, rsp_id, rsp_data, busy);
    end
    rstn = 1;
    req = 4'b1000;
    push(3);
    tick();
    compared++;
    if (gnt !== 4'b1000) begin
      mismatched++;
      $display("FAIL abort_regrant: got gnt=%b, required 1000", gnt);
    end
    wait_rsp(1, "abort_rsp");
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_data(8'h31, 8'h42, 8'h53, 8'h64);
    req = 4'b0011;
    push(0); push(1); push(0); push(1);
    wait_rsp(4, "b2b");
    req = 4'b0010;
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_pulse();
    int base;
    base = rsp_seen;
    set_data(8'h71, 8'h82, 8'h93, 8'hA4);
    req = 4'b0001;
    push(0);
    tick();
    req = '0;
    wait_rsp(1, "pulse");
    tick();
    tick();
    req = 4'b0100;
    push(2);
    tick();
    req = 4'b1011;
    tick();
    req = '0;
    wait_rsp(1, "toggle");
    repeat (5) tick();
    compared++;
    if (rsp_seen != base + 2 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL pulse_count: got %0d responses busy=%b, required 2 busy=0", rsp_seen - base, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_ptr_order();
    test_reset_abort();
    test_back_to_back();
    test_pulse();
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
